// File: rtl/spi_reg_pkg.sv
// Shared types and sizing helpers for the SPI register bank and its write-port arbiter.
package spi_reg_pkg;

    typedef enum logic {
        OWNER_SPI = 1'b0,
        OWNER_BUS = 1'b1
    } arb_owner_t;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_REG_W  = 8;

    function automatic int unsigned nregs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/spi_reg_arb_rr.sv
// Two-way round-robin arbiter for the bank write port; last_win moves only on contested cycles.
module spi_reg_arb_rr
    import spi_reg_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic req_spi,
    input  logic req_bus,
    output logic gnt_spi,
    output logic gnt_bus
);

    arb_owner_t last_win_q, last_win_d;
    logic       contested;

    assign contested = en & req_spi & req_bus;

    always_comb begin
        gnt_spi    = 1'b0;
        gnt_bus    = 1'b0;
        last_win_d = last_win_q;
        if (en) begin
            if (req_spi && req_bus) begin
                // On contention the owner that did not win last time goes next.
                if (last_win_q == OWNER_BUS) begin
                    gnt_spi = 1'b1;
                end else begin
                    gnt_bus = 1'b1;
                end
            end else begin
                gnt_spi = req_spi;
                gnt_bus = req_bus;
            end
        end
        if (contested) begin
            last_win_d = gnt_spi ? OWNER_SPI : OWNER_BUS;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_win_q <= OWNER_BUS;
        end else begin
            last_win_q <= last_win_d;
        end
    end

endmodule

// File: rtl/spi_reg_bank_arbiter.sv
// Register bank shared by the SPI slave (via a one-deep pending buffer) and a local bus,
// with per-register dirty flags and a sticky SPI overflow flag.
module spi_reg_bank_arbiter
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned REG_W  = DEF_REG_W
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     ena,
    input  logic [ADDR_W-1:0]        spi_addr,
    input  logic [REG_W-1:0]         spi_wdata,
    input  logic                     spi_wr_dv,
    output logic [REG_W-1:0]         spi_rdata,
    input  logic                     bus_req,
    input  logic                     bus_we,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [REG_W-1:0]         bus_wdata,
    output logic                     bus_gnt,
    output logic [REG_W-1:0]         bus_rdata,
    output logic [(2**ADDR_W)-1:0]   dirty,
    output logic                     spi_ovf,
    input  logic                     ovf_clr
);

    localparam int unsigned NREGS = nregs(ADDR_W);

    logic [REG_W-1:0]  bank_q [NREGS];

    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [REG_W-1:0]  pend_data_q, pend_data_d;

    logic [REG_W-1:0]  bus_rdata_q, bus_rdata_d;
    logic [NREGS-1:0]  dirty_q, dirty_d;
    logic              ovf_q, ovf_d;

    logic              cand_bus;
    logic              gnt_spi, gnt_bus;
    logic              rd_gnt;
    logic              strobe;

    assign cand_bus = bus_req & bus_we;
    assign rd_gnt   = ena & bus_req & ~bus_we;
    assign strobe   = ena & spi_wr_dv;

    spi_reg_arb_rr u_arb (
        .clk     (clk),
        .rstb    (rstb),
        .en      (ena),
        .req_spi (pend_vld_q),
        .req_bus (cand_bus),
        .gnt_spi (gnt_spi),
        .gnt_bus (gnt_bus)
    );

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        if (ena && ovf_clr) begin
            ovf_d = 1'b0;
        end
        // A new strobe always lands; it only overflows when it displaces an uncommitted entry.
        if (strobe) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = spi_addr;
            pend_data_d = spi_wdata;
            if (pend_vld_q && !gnt_spi) begin
                ovf_d = 1'b1;
            end
        end else if (gnt_spi) begin
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rd_gnt && bus_addr == ADDR_W'(i)) begin
                dirty_d[i] = 1'b0;
            end
            if (gnt_spi && pend_addr_q == ADDR_W'(i)) begin
                dirty_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        bus_rdata_d = bus_rdata_q;
        if (rd_gnt) begin
            bus_rdata_d = bank_q[bus_addr];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (gnt_spi) begin
            bank_q[pend_addr_q] <= pend_data_q;
        end else if (gnt_bus) begin
            bank_q[bus_addr] <= bus_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            bus_rdata_q <= '0;
            dirty_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            bus_rdata_q <= bus_rdata_d;
            dirty_q     <= dirty_d;
            ovf_q       <= ovf_d;
        end
    end

    assign spi_rdata = bank_q[spi_addr];
    assign bus_gnt   = rd_gnt | gnt_bus;
    assign bus_rdata = bus_rdata_q;
    assign dirty     = dirty_q;
    assign spi_ovf   = ovf_q;

endmodule

// File: tb/tb_spi_reg_bank_arbiter.sv
// Directed bench for spi_reg_bank_arbiter with hand-computed expectations.
module tb_spi_reg_bank_arbiter;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned REG_W  = 8;

    logic              clk = 1'b0;
    logic              rstb;
    logic              ena;
    logic [ADDR_W-1:0] spi_addr;
    logic [REG_W-1:0]  spi_wdata;
    logic              spi_wr_dv;
    logic [REG_W-1:0]  spi_rdata;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [REG_W-1:0]  bus_wdata;
    logic              bus_gnt;
    logic [REG_W-1:0]  bus_rdata;
    logic [7:0]        dirty;
    logic              spi_ovf;
    logic              ovf_clr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    spi_reg_bank_arbiter #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_wr_dv (spi_wr_dv),
        .spi_rdata (spi_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_rdata (bus_rdata),
        .dirty     (dirty),
        .spi_ovf   (spi_ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic peek(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] exp, input string tag);
        spi_addr = a;
        settle();
        check(tag, 32'(spi_rdata), 32'(exp));
    endtask

    task automatic idle();
        spi_wr_dv = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1;
        spi_addr = '0; spi_wdata = '0; spi_wr_dv = 1'b0;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        ovf_clr = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
        settle();
        check("rst_spi_rdata", 32'(spi_rdata), 32'h0);
        check("rst_bus_rdata", 32'(bus_rdata), 32'h0);
        check("rst_bus_gnt",   32'(bus_gnt),   32'h0);
        check("rst_dirty",     32'(dirty),     32'h0);
        check("rst_ovf",       32'(spi_ovf),   32'h0);

        // 1: SPI strobe addr3=A5, visible two cycles later
        tick();
        spi_wr_dv = 1'b1; spi_addr = 3'd3; spi_wdata = 8'hA5;
        tick();
        idle();
        peek(3'd3, 8'h00, "t1_not_yet");
        tick();
        peek(3'd3, 8'hA5, "t1_visible");
        check("t1_dirty", 32'(dirty), 32'h08);

        // 2: local read addr3
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd3;
        settle();
        check("t2_gnt", 32'(bus_gnt), 32'h1);
        tick();
        idle();
        settle();
        check("t2_rdata", 32'(bus_rdata), 32'hA5);
        check("t2_dirty", 32'(dirty), 32'h00);
        check("t2_gnt_low", 32'(bus_gnt), 32'h0);

        // 3: first contention after reset goes to SPI
        spi_wr_dv = 1'b1; spi_addr = 3'd1; spi_wdata = 8'h11;
        tick();
        spi_wr_dv = 1'b0;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd2; bus_wdata = 8'h22;
        settle();
        check("t3_bus_waits", 32'(bus_gnt), 32'h0);
        tick();
        check("t3_bus_next", 32'(bus_gnt), 32'h1);
        peek(3'd1, 8'h11, "t3_spi_first");
        tick();
        idle();
        peek(3'd2, 8'h22, "t3_bus_data");
        check("t3_dirty", 32'(dirty), 32'h02);

        // 4: bus wins next contention; second strobe overwrites pend and overflows
        spi_wr_dv = 1'b1; spi_addr = 3'd4; spi_wdata = 8'h44;
        tick();
        spi_wdata = 8'h4F;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd6; bus_wdata = 8'h66;
        settle();
        check("t4_bus_wins", 32'(bus_gnt), 32'h1);
        tick();
        idle();
        settle();
        check("t4_ovf_set", 32'(spi_ovf), 32'h1);
        tick();
        peek(3'd4, 8'h4F, "t4_overwrite");
        peek(3'd6, 8'h66, "t4_bus_data");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        settle();
        check("t4_ovf_clr", 32'(spi_ovf), 32'h0);

        // 4b: strobe in the cycle the pend commits loads without overflow
        spi_wr_dv = 1'b1; spi_addr = 3'd7; spi_wdata = 8'h77;
        tick();
        spi_wdata = 8'h78;
        tick();
        idle();
        settle();
        check("t4b_no_ovf", 32'(spi_ovf), 32'h0);
        peek(3'd7, 8'h77, "t4b_first");
        tick();
        peek(3'd7, 8'h78, "t4b_second");
        check("t4b_dirty", 32'(dirty), 32'h92);

        // 5: SPI commit and local read of addr5 in the same cycle
        spi_wr_dv = 1'b1; spi_addr = 3'd5; spi_wdata = 8'h5A;
        tick();
        spi_wr_dv = 1'b0;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd5;
        settle();
        check("t5_gnt", 32'(bus_gnt), 32'h1);
        tick();
        idle();
        settle();
        check("t5_old_data", 32'(bus_rdata), 32'h00);
        check("t5_dirty_set_wins", 32'(dirty), 32'hB2);
        peek(3'd5, 8'h5A, "t5_new_data");
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd1;
        tick();
        idle();
        settle();
        check("t5_rd1", 32'(bus_rdata), 32'h11);
        check("t5_dirty_clr", 32'(dirty), 32'hB0);

        // 6: ena=0 holds everything; async reset drops pend
        spi_wr_dv = 1'b1; spi_addr = 3'd0; spi_wdata = 8'hEE;
        tick();
        ena = 1'b0;
        spi_wdata = 8'hDD; spi_addr = 3'd2;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd5;
        settle();
        check("t6_no_gnt", 32'(bus_gnt), 32'h0);
        tick();
        idle();
        peek(3'd0, 8'h00, "t6_no_commit");
        check("t6_dirty_hold", 32'(dirty), 32'hB0);
        ena = 1'b1;
        #2;
        rstb = 1'b0;
        #1;
        peek(3'd4, 8'h00, "t6_bank_clr");
        check("t6_dirty_clr", 32'(dirty), 32'h00);
        check("t6_rdata_clr", 32'(bus_rdata), 32'h00);
        tick();
        rstb = 1'b1;
        tick();
        tick();
        peek(3'd0, 8'h00, "t6_pend_dropped");
        peek(3'd2, 8'h00, "t6_lost_strobe");
        check("t6_dirty_after", 32'(dirty), 32'h00);
        check("t6_ovf_after", 32'(spi_ovf), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
